// File: rtl/dist_sq_seq_pkg.sv
// Shared definitions for the dist_sq_seq block.
//   state_t      : FSM state encoding of the sequencer
//   SQ_N         : default signed component width
//   K            : number of leading bits the DRUM squarer keeps
//   POST_SHIFT   : right shift applied to every squarer result
package dist_sq_seq_pkg;

  localparam int SQ_N       = 16;
  localparam int K          = 5;
  localparam int POST_SHIFT = 8;

  typedef enum logic [2:0] {
    IDLE,
    SQ_X,
    SQ_Y,
    SQ_Z,
    DONE
  } state_t;

endpackage

// File: rtl/dist_sq_seq_if.sv
// Handshake bundle for dist_sq_seq.
//   in_valid/in_ready   : input vector handshake
//   in_x/in_y/in_z      : signed components, N bits each
//   in_2d               : ignore in_z, sum x^2+y^2 only
//   out_valid/out_ready : result handshake
//   out_sum             : approximate squared length, OUT_W bits
// The slave modport is the dist_sq_seq side; master is the producer/consumer.
interface dist_sq_seq_if
  import dist_sq_seq_pkg::*;
#(
  parameter int N     = SQ_N,
  parameter int OUT_W = 32
);

  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] in_x;
  logic signed [N-1:0] in_y;
  logic signed [N-1:0] in_z;
  logic                in_2d;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    out_sum;

  modport master (
    output in_valid, in_x, in_y, in_z, in_2d, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_x, in_y, in_z, in_2d, out_ready,
    output in_ready, out_valid, out_sum
  );

endinterface

// File: rtl/dist_sq_seq_square.sv
// DRUM approximate squarer (combinational).
//   a  : signed operand, N bits; -2^(N-1) is squared as magnitude 2^(N-1)
//   sq : (approx a^2) >> POST_SHIFT, 2*N-POST_SHIFT bits
// Magnitudes below 2^K are squared exactly. Larger magnitudes keep the K bits
// starting at the leading one, force the lowest kept bit to 1 (unbiasing the
// dropped tail), square that, and shift back by twice the dropped width.
module dist_sq_seq_square
  import dist_sq_seq_pkg::*;
#(
  parameter int N = SQ_N
) (
  input  logic signed [N-1:0]            a,
  output logic        [2*N-POST_SHIFT-1:0] sq
);

  localparam int PW = $clog2(N);

  logic [N-1:0]   a_u;
  logic [N-1:0]   mag;
  logic [PW-1:0]  lead;
  logic [PW-1:0]  shift;
  logic [K-1:0]   mant;
  logic [2*K-1:0] prod;
  logic [2*N-1:0] full;

  assign a_u = a;

  // NOTE: combinational logic uses blocking assignments, and every variable
  // gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    mag   = a_u[N-1] ? (~a_u + 1'b1) : a_u;
    lead  = '0;
    shift = '0;
    mant  = '0;
    for (int i = 0; i < N; i++) begin
      if (mag[i]) lead = PW'(i);
    end
    if (lead < PW'(K)) begin
      mant = mag[K-1:0];
    end else begin
      shift = lead - PW'(K - 1);
      mant  = K'(mag >> shift) | K'(1);
    end
    prod = mant * mant;
    full = {{(2*N-2*K){1'b0}}, prod} << {shift, 1'b0};
    sq   = (2*N-POST_SHIFT)'(full >> POST_SHIFT);
  end

endmodule

// File: rtl/dist_sq_seq.sv
// Sequential approximate squared-length unit.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dist_sq_seq_if.slave handshake bundle
// One shared DRUM squarer processes x, y and (unless in_2d) z on consecutive
// cycles, accumulating into the result register. The result is held in DONE
// until taken; a new vector may be accepted in the same cycle it leaves.
module dist_sq_seq
  import dist_sq_seq_pkg::*;
#(
  parameter int N     = SQ_N,
  parameter int OUT_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  dist_sq_seq_if.slave  bus
);

  localparam int SQ_W = 2*N - POST_SHIFT;

  state_t              state;
  logic signed [N-1:0] x_q;
  logic signed [N-1:0] y_q;
  logic signed [N-1:0] z_q;
  logic                is_2d_q;
  logic [OUT_W-1:0]    acc;
  logic                out_valid_q;
  logic                in_ready;
  logic                accept;
  logic signed [N-1:0] operand;
  logic [SQ_W-1:0]     sq;

  // in_ready is combinational on out_ready so DONE can hand off back-to-back.
  assign in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = acc;

  always_comb begin
    operand = x_q;
    case (state)
      SQ_Y:    operand = y_q;
      SQ_Z:    operand = z_q;
      default: operand = x_q;
    endcase
  end

  dist_sq_seq_square #(.N(N)) square (
    .a  (operand),
    .sq (sq)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      is_2d_q     <= 1'b0;
      acc         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x_q     <= bus.in_x;
            y_q     <= bus.in_y;
            z_q     <= bus.in_z;
            is_2d_q <= bus.in_2d;
            acc     <= '0;
            state   <= SQ_X;
          end
        end
        SQ_X: begin
          acc   <= acc + OUT_W'(sq);
          state <= SQ_Y;
        end
        SQ_Y: begin
          acc <= acc + OUT_W'(sq);
          if (is_2d_q) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            state <= SQ_Z;
          end
        end
        SQ_Z: begin
          acc         <= acc + OUT_W'(sq);
          state       <= DONE;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (bus.in_valid) begin
              x_q     <= bus.in_x;
              y_q     <= bus.in_y;
              z_q     <= bus.in_z;
              is_2d_q <= bus.in_2d;
              acc     <= '0;
              state   <= SQ_X;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dist_sq_seq.sv
// Self-checking bench for dist_sq_seq: directed corner vectors, stall,
// back-to-back, mid-operation reset, and randomized vectors against a
// behavioural DRUM model.
module tb_dist_sq_seq;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  dist_sq_seq_if #(.N(16), .OUT_W(32)) bus ();

  dist_sq_seq #(.N(16), .OUT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // DRUM approximate square: exact below 32; otherwise keep the top 5 bits
  // from the leading one, set the lowest kept bit, square, scale back; >> 8.
  function automatic longint drum_sq(input longint v);
    longint mag;
    longint m;
    int     p;
    mag = (v < 0) ? -v : v;
    p   = 0;
    while ((mag >> (p + 1)) != 0) p++;
    if (mag < 32) return (mag * mag) >> 8;
    m = (mag >> (p - 4)) | 1;
    return ((m * m) << (2 * (p - 4))) >> 8;
  endfunction

  function automatic longint model_sum(input longint x, input longint y, input longint z,
                                       input bit d2);
    return drum_sq(x) + drum_sq(y) + (d2 ? 0 : drum_sq(z));
  endfunction

  function automatic logic signed [15:0] rand_comp();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return 16'sh8000;
    if (r == 1) return 16'sh7FFF;
    if (r == 2) return 16'(signed'($urandom_range(0, 63)) - 32);
    return 16'($urandom);
  endfunction

  task automatic scramble_inputs();
    bus.in_x  = 16'($urandom);
    bus.in_y  = 16'($urandom);
    bus.in_z  = 16'($urandom);
    bus.in_2d = 1'($urandom_range(0, 1));
  endtask

  // Present one vector, check latency and result, optionally stall the
  // consumer for 'stall' extra cycles, then release the result.
  task automatic run_vec(input logic signed [15:0] x, input logic signed [15:0] y,
                         input logic signed [15:0] z, input bit d2, input int stall,
                         input longint exp_sum, input string tag);
    bit got_it;
    int lat;
    bus.in_x      = x;
    bus.in_y      = y;
    bus.in_z      = z;
    bus.in_2d     = d2;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    got_it = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got_it = 1'b1;
        break;
      end
    end
    if (!got_it) begin
      check({tag, " accept_timeout"}, 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    scramble_inputs();
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), d2 ? 64'd3 : 64'd4);
    check({tag, " sum"}, 64'(bus.out_sum), 64'(exp_sum));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check({tag, " hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, " hold_sum"}, 64'(bus.out_sum), 64'(exp_sum));
      check({tag, " hold_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    if (stall > 0) begin
      bus.out_ready = 1'b1;
      #1;
      check({tag, " release_in_ready"}, 64'(bus.in_ready), 64'd1);
    end
    @(posedge clk);
    #1;
    check({tag, " valid_drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    int  lat;
    bit  seen;
    logic signed [15:0] rx, ry, rz;
    bit  rd;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_z      = '0;
    bus.in_2d     = 1'b0;

    #12;
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset out_sum", 64'(bus.out_sum), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_vec(16, 16, 16, 1'b0, 0, 3, "v16");
    run_vec(-16'sd32768, -16'sd32768, -16'sd32768, 1'b0, 0, 14204928, "vmin");
    run_vec(16'sh7FFF, 16'sh7FFF, 16'sh1234, 1'b1, 0, 7872512, "v2d");
    run_vec(16, 16, 16, 1'b0, 5, 3, "vstall");

    // Back-to-back: second vector is accepted on the edge the first leaves.
    bus.in_x = 16; bus.in_y = 16; bus.in_z = 16; bus.in_2d = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("b2b idle_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_x = -16; bus.in_y = 0; bus.in_z = 0; bus.in_2d = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b first_latency", 64'(lat), 64'd4);
    check("b2b first_sum", 64'(bus.out_sum), 64'd3);
    check("b2b in_ready_done", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    check("b2b first_leaves", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b0;
    scramble_inputs();
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b second_latency", 64'(lat), 64'd4);
    check("b2b second_sum", 64'(bus.out_sum), 64'd1);
    @(posedge clk);
    #1;
    check("b2b second_leaves", 64'(bus.out_valid), 64'd0);

    // Reset pulsed while the y component is being squared.
    bus.in_x = 16; bus.in_y = 16; bus.in_z = 16; bus.in_2d = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_mid out_sum", 64'(bus.out_sum), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("rst_mid no_result", 64'(seen), 64'd0);
    run_vec(16, 16, 16, 1'b0, 0, 3, "post_rst");

    // Randomized vectors against the behavioural model.
    for (int n = 0; n < 40; n++) begin
      rx = rand_comp();
      ry = rand_comp();
      rz = rand_comp();
      rd = 1'($urandom_range(0, 1));
      run_vec(rx, ry, rz, rd, int'($urandom_range(0, 2)),
              model_sum(longint'(rx), longint'(ry), longint'(rz), rd), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dist_sq_seq.md
DIST_SQ_SEQ -- requirements
Module: dist_sq_seq

Interface
REQ-001 SHALL have parameter N, default 16, meaning input component width in bits (signed two's complement).
REQ-002 SHALL have parameter OUT_W, default 32, meaning sum output width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, meaning the input vector is presented.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts a vector this cycle.
REQ-007 SHALL have ports in_x, in_y, in_z, input, N each, meaning signed vector components.
REQ-008 SHALL have port in_2d, input, 1, meaning in_z is ignored and the sum covers x and y only.
REQ-009 SHALL have port out_valid, output, 1, meaning out_sum holds a completed result.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 SHALL have port out_sum, output, OUT_W, meaning the approximate x^2+y^2(+z^2), same scaling as one squarer output.

Function
REQ-012 SHALL compute each square with a single time-shared instance of the team's DRUM approximate squarer (K=5, POST_SHIFT=8), one component per cycle.
REQ-013 SHALL use FSM states IDLE, SQ_X, SQ_Y, SQ_Z, DONE.
REQ-014 SHALL accept a vector when in_valid && in_ready, capturing in_x/in_y/in_z/in_2d into registers and clearing the accumulator.
REQ-015 SHALL drive in_ready=1 in IDLE, and in DONE only when out_ready=1; otherwise 0.
REQ-016 SHALL transition IDLE->SQ_X on accept; SQ_X->SQ_Y; SQ_Y->SQ_Z if captured in_2d=0, else SQ_Y->DONE; SQ_Z->DONE.
REQ-017 SHALL, in each SQ_* state, add the squarer output for that state's captured component into the accumulator.
REQ-018 SHALL assert out_valid exactly in DONE; latency from accept edge to out_valid high is 4 cycles (3D) or 3 cycles (2D).
REQ-019 SHALL hold out_sum and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, in DONE with out_ready=1 and in_valid=1, complete the output handshake and accept the new vector in the same cycle, going to SQ_X (back-to-back, no bubble in IDLE).
REQ-021 SHALL, in DONE with out_ready=1 and in_valid=0, go to IDLE.
REQ-022 SHALL ignore input changes after capture; inputs in non-accept cycles have no effect.
REQ-023 SHALL size the accumulator to OUT_W; the maximum squarer output for N=16 is below 2^24, so no overflow handling is needed for defaults.
REQ-024 SHALL treat -2^(N-1) as the squarer does (magnitude 2^(N-1)).

Reset
REQ-025 SHALL, on rst_n=0 at any time including mid-operation, asynchronously force state IDLE, accumulator 0, captured registers 0, out_valid=0, out_sum=0, in_ready=1 (from IDLE).
REQ-026 SHALL discard any partially accumulated vector on reset; no result is emitted for it.

Structure
REQ-027 SHALL place the FSM state enum and the shared squarer constants (N, K, POST_SHIFT) in the project's shared package.
REQ-028 SHALL instantiate exactly one sub-module, square, fed by a state-selected operand mux; no other sub-modules.

Verification
REQ-029 SHALL cover: x=y=z=16, in_2d=0, out_ready=1 -> out_valid high 4 cycles after accept, out_sum=3.
REQ-030 SHALL cover: x=y=z=-32768 -> out_sum=14204928 (each square 4734976).
REQ-031 SHALL cover: x=y=0x7FFF, z=0x1234, in_2d=1 -> out_sum=7872512 after 3 cycles; z has no effect.
REQ-032 SHALL cover: x=y=z=16 with out_ready=0 for 5 cycles in DONE -> out_sum=3 and out_valid held, in_ready=0, then one-cycle release completes the handshake.
REQ-033 SHALL cover: back-to-back vectors (16,16,16) then (-16,0,0), in_valid and out_ready held high -> results 3 then 1, second accept in the cycle the first result leaves.
REQ-034 SHALL cover: rst_n pulsed low during SQ_Y -> out_valid=0, state IDLE, in_ready=1 immediately; a following vector (16,16,16) yields 3 with no residue.
